nonlinear_round_controller: RTL and testbench
=============================================

// Module: nonlinear_round_controller
// PURPOSE
//   Iterative multi-round sequencer for the nonlinear XOR/AND encryption round.
//   Accepts one block plus key over a valid/ready handshake, then applies one round per clock for ROUNDS cycles.
//   Runs a rotating key schedule alongside the rounds and returns the ciphertext over a valid/ready handshake.
//   Sits between the data source and the result sink; processes one block at a time (not pipelined).
// PARAMETERS
//   N       8  data and key width in bits (N >= 2)
//   ROUNDS  4  number of rounds per block (ROUNDS >= 1)
// PORTS
//   clk        input   1          single clock; all state updates on rising edge
//   rst        input   1          asynchronous, active-high reset
//   in_valid   input   1          source presents data_in/key_in
//   in_ready   output  1          block can accept (high only in IDLE)
//   data_in    input   N          plaintext block
//   key_in     input   N          initial round key
//   out_valid  output  1          data_out holds a finished ciphertext
//   out_ready  input   1          sink accepts data_out
//   data_out   output  N          ciphertext (the data register)
//   busy       output  1          high in RUN or DONE
//   round_idx  output  CW         current round, CW = $clog2(ROUNDS+1)
// BEHAVIOUR
//   - Reset: async on rst rising edge. State = IDLE; data_reg, rk_reg and round_idx = 0.
//     Resulting outputs: in_ready=1, out_valid=0, busy=0, data_out=0.
//   - Reset mid-operation: aborts the block with no output. It is held while rst is high.
//   - Round function, with d = data_reg and k = effective key ek:
//       t = d ^ k
//       d_next[i] = t[i] ^ (t[(i+1)%N] & k[i])   (mod-2 sum == XOR)
//     Implemented combinationally inside this block.
//   - Key schedule: rk_next = rotate-left-by-1(rk_reg). Without the optional feature, ek = rk_reg.
//   - FSM states and transitions:
//       IDLE: in_ready=1. On in_valid: data_reg<=data_in, rk_reg<=key_in, round_idx<=0, go to RUN.
//       RUN:  each cycle data_reg<=f(data_reg,ek), rk_reg<=rk_next, round_idx<=round_idx+1.
//             When round_idx==ROUNDS-1, go to DONE.
//       DONE: out_valid=1 and data_out is held stable. On out_ready go to IDLE.
//   - Latency: accept at edge E0; out_valid is high after edge E0+ROUNDS. Throughput is 1 block per ROUNDS+2 cycles.
//   - No same-cycle turnaround: in_ready rises the cycle after the DONE->IDLE handshake.
//   - in_valid is ignored while busy.
//   - out_valid, once high, stays high and data_out stays constant until out_ready (AXI-style rule).
//   - ROUNDS=1: RUN lasts exactly one cycle.
//   - round_idx is reset to 0 on each accept. In DONE it reads ROUNDS.
//   - All arithmetic is N-bit. The index wraps mod N; the round counter never exceeds ROUNDS.
// CONFIGURATION
//   ROUND_CONST_EN defined:
//     ek = rk_reg ^ round_idx, with round_idx zero-extended or truncated to N bits.
//     Breaks key-schedule periodicity.
//   ROUND_CONST_EN undefined:
//     ek = rk_reg exactly.
//     Handshake, FSM and latency are identical in both builds.
// TESTING
//   1. Reset, then idle: in_ready=1, out_valid=0, data_out=0x00, round_idx=0.
//   2. ROUNDS=4, data=0xA5, key=0x00 -> out_valid 4 cycles after accept, data_out=0xA5.
//   3. ROUNDS=1, data=0x00, key=0xFF -> data_out=0x00.
//      ROUNDS=1, data=0xFF, key=0x00 -> data_out=0xFF.
//   4. ROUNDS=2, data=0x00, key=0x01, macro off -> data_out=0x03.
//      ROUNDS=2, data=0x00, key=0x00, macro on  -> data_out=0x01 (macro off gives 0x00).
//   5. out_ready held low 10 cycles in DONE -> out_valid and data_out stable.
//      in_valid pulses while busy are ignored. After out_ready, in_ready=1 on the next cycle.
//   6. Assert rst during RUN round 2 -> immediately IDLE, out_valid=0, data_out=0.
//      The next block then completes correctly.

Source files
------------

// File: rtl/nonlinear_round_controller.sv
// nonlinear_round_controller: iterative XOR/AND round sequencer with a
// rotating key schedule, one block at a time, valid/ready on both sides.
// Ports: clk, rst (async, active high); in_valid/in_ready/data_in/key_in
// accept a block; out_valid/out_ready/data_out return the ciphertext;
// busy is high in RUN or DONE; round_idx is the current round count.
// Build option: define ROUND_CONST_EN to XOR round_idx into the key.
module nonlinear_round_controller #(
  parameter  int N      = 8,
  parameter  int ROUNDS = 4,
  localparam int CW     = $clog2(ROUNDS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  data_in,
  input  logic [N-1:0]  key_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  data_out,
  output logic          busy,
  output logic [CW-1:0] round_idx
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0] LAST = CW'(ROUNDS - 1);

  logic [1:0]    r_state;
  logic [N-1:0]  r_data;
  logic [N-1:0]  r_rk;
  logic [CW-1:0] r_idx;

  logic [N-1:0]  w_ek;
  logic [N-1:0]  w_t;
  logic [N-1:0]  w_rot;
  logic [N-1:0]  w_next;
  logic [N-1:0]  w_rk_next;

`ifdef ROUND_CONST_EN
  // Round counter mixed into the key breaks the period-N key cycle.
  assign w_ek = r_rk ^ N'(r_idx);
`else
  assign w_ek = r_rk;
`endif

  // w_rot[i] = w_t[(i+1) % N]: rotate right by one.
  always_comb begin
    w_t       = r_data ^ w_ek;
    w_rot     = {w_t[0], w_t[N-1:1]};
    w_next    = w_t ^ (w_rot & w_ek);
    w_rk_next = {r_rk[N-2:0], r_rk[N-1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_data  <= '0;
      r_rk    <= '0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_data  <= data_in;
            r_rk    <= key_in;
            r_idx   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_data <= w_next;
          r_rk   <= w_rk_next;
          r_idx  <= r_idx + CW'(1);
          if (r_idx == LAST) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign data_out  = r_data;
  assign round_idx = r_idx;

endmodule

// File: tb/tb_nonlinear_round_controller.sv
// Bench for nonlinear_round_controller: three instances (ROUNDS 4, 1, 2)
// driven from a vector table plus stall, busy-ignore and reset sequences.
module tb_nonlinear_round_controller;

`ifdef ROUND_CONST_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [2:0] iv;
  logic [2:0] ordy;
  logic [2:0] ir;
  logic [2:0] ov;
  logic [2:0] bz;
  logic [7:0] din;
  logic [7:0] kin;
  logic [7:0] dout [3];
  logic [2:0] ri4;
  logic [0:0] ri1;
  logic [1:0] ri2;

  int rnds [3] = '{4, 1, 2};
  int total = 0;
  int pass  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  nonlinear_round_controller #(.N(8), .ROUNDS(4)) u_r4 (
    .clk(clk), .rst(rst),
    .in_valid(iv[0]), .in_ready(ir[0]),
    .data_in(din), .key_in(kin),
    .out_valid(ov[0]), .out_ready(ordy[0]),
    .data_out(dout[0]), .busy(bz[0]), .round_idx(ri4)
  );

  nonlinear_round_controller #(.N(8), .ROUNDS(1)) u_r1 (
    .clk(clk), .rst(rst),
    .in_valid(iv[1]), .in_ready(ir[1]),
    .data_in(din), .key_in(kin),
    .out_valid(ov[1]), .out_ready(ordy[1]),
    .data_out(dout[1]), .busy(bz[1]), .round_idx(ri1)
  );

  nonlinear_round_controller #(.N(8), .ROUNDS(2)) u_r2 (
    .clk(clk), .rst(rst),
    .in_valid(iv[2]), .in_ready(ir[2]),
    .data_in(din), .key_in(kin),
    .out_valid(ov[2]), .out_ready(ordy[2]),
    .data_out(dout[2]), .busy(bz[2]), .round_idx(ri2)
  );

  function automatic int ridx(input int s);
    case (s)
      0:       return int'(ri4);
      1:       return int'(ri1);
      default: return int'(ri2);
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Entered and left 1 time unit after a rising edge.
  task automatic run_block(input int s, input logic [7:0] d,
                           input logic [7:0] k, input logic [7:0] e,
                           input string tag);
    int lat;
    chk({tag, " in_ready"}, 32'(ir[s]), 32'd1);
    din = d;
    kin = k;
    iv[s] = 1'b1;
    @(posedge clk); #1;
    iv[s] = 1'b0;
    lat = 0;
    while (!ov[s] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(rnds[s]));
    chk({tag, " data_out"}, 32'(dout[s]), 32'(e));
    chk({tag, " round_idx"}, 32'(ridx(s)), 32'(rnds[s]));
    chk({tag, " busy"}, 32'(bz[s]), 32'd1);
    ordy[s] = 1'b1;
    @(posedge clk); #1;
    ordy[s] = 1'b0;
    chk({tag, " in_ready after"}, 32'(ir[s]), 32'd1);
    chk({tag, " out_valid after"}, 32'(ov[s]), 32'd0);
  endtask

  typedef struct {
    int         sel;
    logic [7:0] d;
    logic [7:0] k;
    logic [7:0] e_off;
    logic [7:0] e_on;
  } vec_t;

  vec_t vt [9];

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] e;
    logic       stable;
    int         lat;

    vt[0] = '{0, 8'hA5, 8'h00, 8'hA5, 8'hA4};
    vt[1] = '{0, 8'h00, 8'h01, 8'h0F, 8'h0E};
    vt[2] = '{0, 8'h3C, 8'hF0, 8'hAF, 8'h6D};
    vt[3] = '{1, 8'h00, 8'hFF, 8'h00, 8'h00};
    vt[4] = '{1, 8'hFF, 8'h00, 8'hFF, 8'hFF};
    vt[5] = '{1, 8'h3C, 8'hF0, 8'hAC, 8'hAC};
    vt[6] = '{2, 8'h00, 8'h01, 8'h03, 8'h03};
    vt[7] = '{2, 8'h00, 8'h00, 8'h00, 8'h01};
    vt[8] = '{2, 8'h3C, 8'hF0, 8'hED, 8'h6C};

    rst  = 1'b1;
    iv   = '0;
    ordy = '0;
    din  = '0;
    kin  = '0;
    #2;
    chk("reset in_ready", 32'(ir[0]), 32'd1);
    chk("reset out_valid", 32'(ov[0]), 32'd0);
    chk("reset busy", 32'(bz[0]), 32'd0);
    chk("reset data_out", 32'(dout[0]), 32'd0);
    chk("reset round_idx", 32'(ri4), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle in_ready", 32'(ir[0]), 32'd1);
    chk("idle out_valid", 32'(ov[0]), 32'd0);

    for (int i = 0; i < 9; i++) begin
      e = RC ? vt[i].e_on : vt[i].e_off;
      run_block(vt[i].sel, vt[i].d, vt[i].k, e, $sformatf("vec%0d", i));
    end

    // Stall in DONE with in_valid hammered while busy.
    e = RC ? 8'h6D : 8'hAF;
    din = 8'h3C;
    kin = 8'hF0;
    iv[0] = 1'b1;
    @(posedge clk); #1;
    din = 8'hFF;
    kin = 8'h55;
    lat = 0;
    while (!ov[0] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("stall latency", 32'(lat), 32'd4);
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (ov[0] !== 1'b1 || dout[0] !== e || ir[0] !== 1'b0)
        stable = 1'b0;
      @(posedge clk); #1;
    end
    chk("stall stable", 32'(stable), 32'd1);
    chk("stall data_out", 32'(dout[0]), 32'(e));
    iv[0] = 1'b0;
    chk("stall in_ready low", 32'(ir[0]), 32'd0);
    ordy[0] = 1'b1;
    @(posedge clk); #1;
    ordy[0] = 1'b0;
    chk("stall in_ready after", 32'(ir[0]), 32'd1);

    // Reset during round 2 aborts the block.
    din = 8'h00;
    kin = 8'h01;
    iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort round_idx", 32'(ri4), 32'd2);
    rst = 1'b1;
    #1;
    chk("abort in_ready", 32'(ir[0]), 32'd1);
    chk("abort out_valid", 32'(ov[0]), 32'd0);
    chk("abort busy", 32'(bz[0]), 32'd0);
    chk("abort data_out", 32'(dout[0]), 32'd0);
    chk("abort round_idx0", 32'(ri4), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    e = RC ? 8'h0E : 8'h0F;
    run_block(0, 8'h00, 8'h01, e, "post-abort");

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
